// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Write-side producer for the 32-bit instruction queue. Walks a sequential PC,
//   issues reads to a fixed-latency instruction memory, buffers returned words,
//   and hands them to the queue over valid/ready. Control-flow redirects bump an
//   epoch bit so reads already in flight are dropped when they return.
//
// Ports
//   clk_in             in   1   clock
//   rst_n_in           in   1   asynchronous active-low reset
//   start_in           in   1   leave IDLE and begin fetching
//   redirect_valid_in  in   1   redirect request
//   redirect_pc_in     in   32  redirect target (low two bits ignored)
//   imem_req_out       out  1   read request to instruction memory
//   imem_addr_out      out  32  word-aligned byte address of the request
//   imem_data_in       in   32  read data, IMEM_LATENCY cycles after the request
//   valid_out          out  1   instruction_out valid
//   instruction_out    out  32  fetched instruction (buffer head)
//   ready_in           in   1   queue can accept
//   pc_out             out  32  PC of instruction_out (only with FETCH_PC_OUT_EN)
//
// Build option
//   FETCH_PC_OUT_EN : adds pc_out; the PC rides through the in-flight pipe and
//                     the response buffer alongside the data.
//
// State table
//   S_IDLE  | waiting for start_in; redirects only move the PC
//   S_RUN   | issuing sequential reads while credit allows
//   S_REDIR | one bubble cycle after a redirect, no request issued

`timescale 1ns/1ps

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_LATENCY = 2,
    parameter int          BUF_DEPTH    = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    output logic        valid_out,
    output logic [31:0] instruction_out,
    input  logic        ready_in
`ifdef FETCH_PC_OUT_EN
    ,
    output logic [31:0] pc_out
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(BUF_DEPTH);

`ifdef FETCH_PC_OUT_EN
    localparam int ENTRY_W = 64;
`else
    localparam int ENTRY_W = 32;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] pc;
    logic        epoch;

    logic [IMEM_LATENCY-1:0] pipe_valid;
    logic [IMEM_LATENCY-1:0] pipe_epoch;
`ifdef FETCH_PC_OUT_EN
    logic [31:0] pipe_pc [IMEM_LATENCY];
`endif

    logic [ENTRY_W-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   buf_count;

    logic [SUM_W-1:0]   inflight;
    logic               redirect_active;
    logic               credit_ok;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_in) state_nxt = S_RUN;
            S_RUN:   if (redirect_valid_in) state_nxt = S_REDIR;
            S_REDIR: state_nxt = redirect_valid_in ? S_REDIR : S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- request / credit ----------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i < IMEM_LATENCY; i++) begin
            inflight = inflight + SUM_W'(pipe_valid[i]);
        end
    end

    // Stale reads still occupy a credit until they leave the pipe, so the
    // buffer can never be asked to hold more than BUF_DEPTH entries.
    assign credit_ok       = (inflight + {1'b0, buf_count}) < DEPTH_C;
    assign redirect_active = redirect_valid_in && (state != S_IDLE);
    assign imem_req_out    = (state == S_RUN) && !redirect_valid_in && credit_ok;
    assign imem_addr_out   = pc;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc    <= RESET_PC;
            epoch <= 1'b0;
        end else begin
            if (redirect_valid_in) begin
                pc <= {redirect_pc_in[31:2], 2'b00};
            end else if (imem_req_out) begin
                pc <= pc + 32'd4;
            end
            if (redirect_active) epoch <= ~epoch;
        end
    end

    // ---------------- in-flight pipe ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pipe_valid <= '0;
            pipe_epoch <= '0;
`ifdef FETCH_PC_OUT_EN
            for (int i = 0; i < IMEM_LATENCY; i++) pipe_pc[i] <= '0;
`endif
        end else begin
            for (int i = IMEM_LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_epoch[i] <= pipe_epoch[i-1];
`ifdef FETCH_PC_OUT_EN
                pipe_pc[i]    <= pipe_pc[i-1];
`endif
            end
            pipe_valid[0] <= imem_req_out;
            pipe_epoch[0] <= epoch;
`ifdef FETCH_PC_OUT_EN
            pipe_pc[0]    <= pc;
`endif
        end
    end

    // ---------------- response buffer ----------------
    // Nothing is pushed in a redirect cycle: a word returning then either
    // belongs to the old epoch or would be flushed along with the buffer.
    assign push = pipe_valid[IMEM_LATENCY-1]
               && (pipe_epoch[IMEM_LATENCY-1] == epoch)
               && !redirect_active;
    assign pop  = valid_out && ready_in;

`ifdef FETCH_PC_OUT_EN
    assign entry_in = {pipe_pc[IMEM_LATENCY-1], imem_data_in};
`else
    assign entry_in = imem_data_in;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else if (redirect_active) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= entry_in;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   buf_count <= buf_count + CNT_W'(1);
                2'b01:   buf_count <= buf_count - CNT_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    assign head            = buf_mem[rd_ptr];
    assign valid_out       = (buf_count != '0);
    assign instruction_out = head[31:0];
`ifdef FETCH_PC_OUT_EN
    assign pc_out          = head[63:32];
`endif

endmodule
